// File: rtl/generation_sequencer.sv
// generation_sequencer: command-driven sequencer that validates a clock
// generator configuration, derives its rate/lead thresholds and walks the
// generator through IDLE -> PRIME -> RUN -> DRAIN.
// Optional feature: define GENERATION_SEQUENCER_ERR_COUNT_EN to add an
// 8-bit saturating error-response counter on port err_count_o.

package clks_alot_p;
    localparam int unsigned COUNTER_WIDTH = 16;
endpackage

module generation_sequencer #(
    parameter int unsigned COUNTER_WIDTH = clks_alot_p::COUNTER_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clk_en,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic [1:0]               cmd_op_i,
    input  logic [COUNTER_WIDTH-1:0] cmd_half_period_i,
    input  logic [COUNTER_WIDTH-1:0] cmd_lead_i,
    input  logic                     cmd_polarity_i,
    output logic                     resp_valid_o,
    output logic                     resp_error_o,
    output logic                     generation_en_o,
    output logic                     set_polarity_o,
    output logic                     starting_polarity_o,
    input  logic                     gen_busy_i,
    output logic [COUNTER_WIDTH-1:0] expected_half_rate_minus_two_o,
    output logic [COUNTER_WIDTH-1:0] expected_quarter_rate_minus_one_o,
    output logic [COUNTER_WIDTH-1:0] preemptive_half_rate_minus_one_o,
    output logic [COUNTER_WIDTH-1:0] preemptive_quarter_rate_minus_one_o,
    output logic [1:0]               state_o
`ifdef GENERATION_SEQUENCER_ERR_COUNT_EN
    ,
    output logic [7:0]               err_count_o
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OP_NOP      = 2'd0,
        OP_START    = 2'd1,
        OP_STOP     = 2'd2,
        OP_RECONFIG = 2'd3
    } op_e;

    state_e                   state_q;
    logic                     gen_en_q;
    logic                     set_pol_q;
    logic                     pol_q;
    logic                     resp_valid_q;
    logic                     resp_error_q;
    logic [COUNTER_WIDTH-1:0] exp_half_q;
    logic [COUNTER_WIDTH-1:0] exp_quarter_q;
    logic [COUNTER_WIDTH-1:0] pre_half_q;
    logic [COUNTER_WIDTH-1:0] pre_quarter_q;

    // Pending configuration captured by RECONFIG while running
    logic                     pend_q;
    logic                     pend_pol_q;
    logic [COUNTER_WIDTH-1:0] pend_exp_half_q;
    logic [COUNTER_WIDTH-1:0] pend_exp_quarter_q;
    logic [COUNTER_WIDTH-1:0] pend_pre_half_q;
    logic [COUNTER_WIDTH-1:0] pend_pre_quarter_q;

    logic [COUNTER_WIDTH-1:0] quarter_d;
    logic [COUNTER_WIDTH-1:0] exp_half_d;
    logic [COUNTER_WIDTH-1:0] exp_quarter_d;
    logic [COUNTER_WIDTH-1:0] pre_half_d;
    logic [COUNTER_WIDTH-1:0] pre_quarter_d;
    logic                     cfg_ok_d;
    logic                     accept_d;
    logic                     cmd_err_d;
    op_e                      op_d;

    assign cmd_ready_o = !rst && ((state_q == IDLE) || (state_q == RUN));

    // Decode the offered command: derived thresholds, validity and error outcome
    always_comb begin
        op_d          = op_e'(cmd_op_i);
        quarter_d     = cmd_half_period_i >> 1;
        cfg_ok_d      = (cmd_half_period_i >= COUNTER_WIDTH'(4)) && (cmd_lead_i < quarter_d);
        exp_half_d    = cmd_half_period_i - COUNTER_WIDTH'(2);
        exp_quarter_d = quarter_d - COUNTER_WIDTH'(1);
        pre_half_d    = cmd_half_period_i - cmd_lead_i - COUNTER_WIDTH'(1);
        pre_quarter_d = quarter_d - cmd_lead_i - COUNTER_WIDTH'(1);
        accept_d      = cmd_valid_i && cmd_ready_o && clk_en;
        cmd_err_d     = 1'b0;
        if (accept_d) begin
            if (op_d == OP_START)
                cmd_err_d = (state_q == RUN) || !cfg_ok_d;
            else if (op_d == OP_RECONFIG)
                cmd_err_d = !cfg_ok_d;
        end
    end

    // Sequencer FSM with registered outputs; everything freezes while clk_en is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q            <= IDLE;
            gen_en_q           <= 1'b0;
            set_pol_q          <= 1'b0;
            pol_q              <= 1'b0;
            resp_valid_q       <= 1'b0;
            resp_error_q       <= 1'b0;
            exp_half_q         <= '0;
            exp_quarter_q      <= '0;
            pre_half_q         <= '0;
            pre_quarter_q      <= '0;
            pend_q             <= 1'b0;
            pend_pol_q         <= 1'b0;
            pend_exp_half_q    <= '0;
            pend_exp_quarter_q <= '0;
            pend_pre_half_q    <= '0;
            pend_pre_quarter_q <= '0;
        end else if (clk_en) begin
            resp_valid_q <= accept_d;
            resp_error_q <= cmd_err_d;
            set_pol_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_d && cfg_ok_d &&
                        ((op_d == OP_START) || (op_d == OP_RECONFIG))) begin
                        exp_half_q    <= exp_half_d;
                        exp_quarter_q <= exp_quarter_d;
                        pre_half_q    <= pre_half_d;
                        pre_quarter_q <= pre_quarter_d;
                        pol_q         <= cmd_polarity_i;
                        if (op_d == OP_START) begin
                            set_pol_q <= 1'b1;
                            state_q   <= PRIME;
                        end
                    end
                end
                PRIME: begin
                    gen_en_q <= 1'b1;
                    state_q  <= RUN;
                end
                RUN: begin
                    if (accept_d) begin
                        if (op_d == OP_STOP) begin
                            gen_en_q <= 1'b0;
                            state_q  <= DRAIN;
                        end else if ((op_d == OP_RECONFIG) && cfg_ok_d) begin
                            pend_q             <= 1'b1;
                            pend_pol_q         <= cmd_polarity_i;
                            pend_exp_half_q    <= exp_half_d;
                            pend_exp_quarter_q <= exp_quarter_d;
                            pend_pre_half_q    <= pre_half_d;
                            pend_pre_quarter_q <= pre_quarter_d;
                            gen_en_q           <= 1'b0;
                            state_q            <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!gen_busy_i) begin
                        if (pend_q) begin
                            exp_half_q    <= pend_exp_half_q;
                            exp_quarter_q <= pend_exp_quarter_q;
                            pre_half_q    <= pend_pre_half_q;
                            pre_quarter_q <= pend_pre_quarter_q;
                            pol_q         <= pend_pol_q;
                            pend_q        <= 1'b0;
                            set_pol_q     <= 1'b1;
                            state_q       <= PRIME;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef GENERATION_SEQUENCER_ERR_COUNT_EN
    logic [7:0] err_cnt_q;

    // Saturating count of error responses, stepped when the error is issued
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_cnt_q <= '0;
        else if (cmd_err_d && (err_cnt_q != 8'hFF))
            err_cnt_q <= err_cnt_q + 8'd1;
    end

    assign err_count_o = err_cnt_q;
`endif

    assign resp_valid_o                        = resp_valid_q;
    assign resp_error_o                        = resp_error_q;
    assign generation_en_o                     = gen_en_q;
    assign set_polarity_o                      = set_pol_q;
    assign starting_polarity_o                 = pol_q;
    assign expected_half_rate_minus_two_o      = exp_half_q;
    assign expected_quarter_rate_minus_one_o   = exp_quarter_q;
    assign preemptive_half_rate_minus_one_o    = pre_half_q;
    assign preemptive_quarter_rate_minus_one_o = pre_quarter_q;
    assign state_o                             = state_q;

endmodule

// File: tb/tb_generation_sequencer.sv
// Self-checking bench for generation_sequencer: directed scenarios followed
// by randomized commands, compared against a transaction-level model.
module tb_generation_sequencer;

    localparam int W    = 16;
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clk_en = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = 2'd0;
    logic [W-1:0] cmd_h = '0;
    logic [W-1:0] cmd_l = '0;
    logic         cmd_pol = 1'b0;
    logic         resp_valid, resp_error, gen_en, set_pol, start_pol;
    logic         busy = 1'b0;
    logic [W-1:0] eh, eq, ph, pq;
    logic [1:0]   state;
`ifdef GENERATION_SEQUENCER_ERR_COUNT_EN
    logic [7:0]   err_count;
`endif

    generation_sequencer #(.COUNTER_WIDTH(W)) dut (
        .clk                                 (clk),
        .rst                                 (rst),
        .clk_en                              (clk_en),
        .cmd_valid_i                         (cmd_valid),
        .cmd_ready_o                         (cmd_ready),
        .cmd_op_i                            (cmd_op),
        .cmd_half_period_i                   (cmd_h),
        .cmd_lead_i                          (cmd_l),
        .cmd_polarity_i                      (cmd_pol),
        .resp_valid_o                        (resp_valid),
        .resp_error_o                        (resp_error),
        .generation_en_o                     (gen_en),
        .set_polarity_o                      (set_pol),
        .starting_polarity_o                 (start_pol),
        .gen_busy_i                          (busy),
        .expected_half_rate_minus_two_o      (eh),
        .expected_quarter_rate_minus_one_o   (eq),
        .preemptive_half_rate_minus_one_o    (ph),
        .preemptive_quarter_rate_minus_one_o (pq),
        .state_o                             (state)
`ifdef GENERATION_SEQUENCER_ERR_COUNT_EN
        ,
        .err_count_o                         (err_count)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: modes 0 idle, 1 prime, 2 run, 3 drain
    int m_mode, m_gen, m_sp, m_pol, m_rv, m_re, m_eh, m_eq, m_ph, m_pq, m_errc;
    int m_pend, m_pend_h, m_pend_l, m_pend_pol;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit cfg_ok(input int h, input int l);
        return (h >= 4) && (l < h / 2);
    endfunction

    function automatic void model_load(input int h, input int l, input int pol);
        m_eh  = (h - 2) & MASK;
        m_eq  = (h / 2 - 1) & MASK;
        m_ph  = (h - l - 1) & MASK;
        m_pq  = (h / 2 - l - 1) & MASK;
        m_pol = pol;
    endfunction

    function automatic void model_reset();
        m_mode = 0; m_gen = 0; m_sp = 0; m_pol = 0; m_rv = 0; m_re = 0;
        m_eh = 0; m_eq = 0; m_ph = 0; m_pq = 0; m_errc = 0;
        m_pend = 0; m_pend_h = 0; m_pend_l = 0; m_pend_pol = 0;
    endfunction

    function automatic void model_error();
        m_re = 1;
        if (m_errc < 255) m_errc++;
    endfunction

    // Apply the sequencing rules for one enabled clock edge
    function automatic void model_edge();
        int h, l, op;
        bit acc, ok;
        if (!clk_en) return;
        h   = int'(cmd_h);
        l   = int'(cmd_l);
        op  = int'(cmd_op);
        ok  = cfg_ok(h, l);
        acc = cmd_valid && (m_mode == 0 || m_mode == 2);
        m_rv = acc ? 1 : 0;
        m_re = 0;
        m_sp = 0;
        if (m_mode == 0) begin
            if (acc && op == 1) begin
                if (ok) begin
                    model_load(h, l, int'(cmd_pol));
                    m_mode = 1;
                    m_sp   = 1;
                end else model_error();
            end else if (acc && op == 3) begin
                if (ok) model_load(h, l, int'(cmd_pol));
                else model_error();
            end
        end else if (m_mode == 1) begin
            m_mode = 2;
            m_gen  = 1;
        end else if (m_mode == 2) begin
            if (acc && op == 2) begin
                m_mode = 3;
                m_gen  = 0;
            end else if (acc && op == 1) begin
                model_error();
            end else if (acc && op == 3) begin
                if (ok) begin
                    m_pend = 1; m_pend_h = h; m_pend_l = l; m_pend_pol = int'(cmd_pol);
                    m_mode = 3;
                    m_gen  = 0;
                end else model_error();
            end
        end else begin
            if (!busy) begin
                if (m_pend != 0) begin
                    model_load(m_pend_h, m_pend_l, m_pend_pol);
                    m_pend = 0;
                    m_sp   = 1;
                    m_mode = 1;
                end else m_mode = 0;
            end
        end
    endfunction

    task automatic compare_all();
        check_eq("state", 32'(state), 32'(m_mode));
        check_eq("ready", 32'(cmd_ready), (!rst && (m_mode == 0 || m_mode == 2)) ? 32'd1 : 32'd0);
        check_eq("resp_valid", 32'(resp_valid), 32'(m_rv));
        check_eq("resp_error", 32'(resp_error), 32'(m_re));
        check_eq("gen_en", 32'(gen_en), 32'(m_gen));
        check_eq("set_pol", 32'(set_pol), 32'(m_sp));
        check_eq("start_pol", 32'(start_pol), 32'(m_pol));
        check_eq("exp_half", 32'(eh), 32'(m_eh));
        check_eq("exp_quarter", 32'(eq), 32'(m_eq));
        check_eq("pre_half", 32'(ph), 32'(m_ph));
        check_eq("pre_quarter", 32'(pq), 32'(m_pq));
`ifdef GENERATION_SEQUENCER_ERR_COUNT_EN
        check_eq("err_count", 32'(err_count), 32'(m_errc));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    // Assert reset mid-cycle, check immediate effect, release mid-cycle
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_eq("rst_gen_drop", 32'(gen_en), 32'd0);
        compare_all();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_eq("rel_ready", 32'(cmd_ready), 32'd1);
        compare_all();
    endtask

    task automatic drive(input bit v, input int op, input int h, input int l, input bit pol);
        cmd_valid = v;
        cmd_op    = 2'(op);
        cmd_h     = W'(h);
        cmd_l     = W'(l);
        cmd_pol   = pol;
    endtask

    initial begin
        model_reset();
        #1;
        compare_all();
        @(posedge clk);
        #3;
        rst    = 1'b0;
        clk_en = 1'b1;
        #1;
        check_eq("rel_ready", 32'(cmd_ready), 32'd1);
        compare_all();

        // Invalid STARTs: H too small, then lead not below quarter
        drive(1, 1, 3, 0, 1); step();
        check_eq("inv_h_err", 32'(resp_error), 32'd1);
        check_eq("inv_h_state", 32'(state), 32'd0);
        check_eq("inv_h_out", 32'(eh), 32'd0);
        drive(1, 1, 8, 4, 1); step();
        check_eq("inv_l_err", 32'(resp_error), 32'd1);

        // START H=16 L=3 pol=1
        drive(1, 1, 16, 3, 1); step();
        check_eq("st_rv", 32'(resp_valid), 32'd1);
        check_eq("st_re", 32'(resp_error), 32'd0);
        check_eq("st_sp", 32'(set_pol), 32'd1);
        check_eq("st_eh", 32'(eh), 32'd14);
        check_eq("st_eq", 32'(eq), 32'd7);
        check_eq("st_ph", 32'(ph), 32'd12);
        check_eq("st_pq", 32'(pq), 32'd4);
        drive(0, 0, 0, 0, 0); step();
        check_eq("run_gen", 32'(gen_en), 32'd1);
        check_eq("run_sp", 32'(set_pol), 32'd0);

        // START while running is rejected
        drive(1, 1, 16, 3, 0); step();
        check_eq("run_start_err", 32'(resp_error), 32'd1);
        check_eq("run_start_state", 32'(state), 32'd2);

        // RECONFIG H=20 L=2 with the generator busy for five cycles
        busy = 1'b1;
        drive(1, 3, 20, 2, 0); step();
        check_eq("rc_drain", 32'(state), 32'd3);
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("rc_hold_eh", 32'(eh), 32'd14);
        end
        busy = 1'b0;
        step();
        check_eq("rc_prime", 32'(state), 32'd1);
        check_eq("rc_eh", 32'(eh), 32'd18);
        check_eq("rc_eq", 32'(eq), 32'd9);
        check_eq("rc_ph", 32'(ph), 32'd17);
        check_eq("rc_pq", 32'(pq), 32'd7);
        step();
        check_eq("rc_run", 32'(state), 32'd2);

        // Response pulse stretched by clk_en low
        drive(1, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0);
        clk_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("hold_rv", 32'(resp_valid), 32'd1);
        end
        clk_en = 1'b1;
        step();
        check_eq("hold_rv_end", 32'(resp_valid), 32'd0);

        // STOP with generator idle: one DRAIN cycle, back to IDLE
        drive(1, 2, 0, 0, 0); step();
        check_eq("stop_drain", 32'(state), 32'd3);
        drive(0, 0, 0, 0, 0); step();
        check_eq("stop_idle", 32'(state), 32'd0);

        // Asynchronous reset while running
        drive(1, 1, 16, 3, 1); step();
        drive(0, 0, 0, 0, 0); step();
        check_eq("pre_rst_gen", 32'(gen_en), 32'd1);
        do_reset();

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            int hs, h, l;
            hs = $urandom_range(0, 3);
            h  = (hs == 0) ? $urandom_range(0, 6) :
                 (hs == 1) ? $urandom_range(4, 64) : ($urandom() & MASK);
            l  = ($urandom_range(0, 7) == 0) ? ($urandom() & MASK) : $urandom_range(0, 20);
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 3), h, l, $urandom_range(0, 1) == 1);
            clk_en = ($urandom_range(0, 7) != 0);
            busy   = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 499) == 0) do_reset();
            step();
        end
        clk_en = 1'b1;
        busy   = 1'b0;

`ifdef GENERATION_SEQUENCER_ERR_COUNT_EN
        do_reset();
        drive(1, 1, 3, 0, 0);
        for (int i = 0; i < 300; i++) step();
        drive(0, 0, 0, 0, 0);
        step();
        check_eq("errc_sat", 32'(err_count), 32'd255);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/generation_sequencer.md
GENERATION_SEQUENCER -- requirements
Module: generation_sequencer

Interface
REQ-001 SHALL have parameter COUNTER_WIDTH, default clks_alot_p::COUNTER_WIDTH, width of all rate/lead fields.
REQ-002 SHALL have ports, one per line:
 clk  input  1  sole clock, all state on rising edge
 rst  input  1  reset, asynchronous, active-high
 clk_en  input  1  qualifies every state update; low = full freeze
 cmd_valid_i  input  1  command offered
 cmd_ready_o  output  1  command accepted when valid&&ready&&clk_en
 cmd_op_i  input  2  00 NOP, 01 START, 10 STOP, 11 RECONFIG
 cmd_half_period_i  input  COUNTER_WIDTH  half period, sys cycles
 cmd_lead_i  input  COUNTER_WIDTH  preemptive lead, sys cycles
 cmd_polarity_i  input  1  starting polarity
 resp_valid_o  output  1  one-cycle response pulse
 resp_error_o  output  1  error flag, valid with resp_valid_o
 generation_en_o  output  1  to generator enable
 set_polarity_o  output  1  one-cycle polarity load pulse
 starting_polarity_o  output  1  latched polarity
 gen_busy_i  input  1  generator busy
 expected_half_rate_minus_two_o  output  COUNTER_WIDTH
 expected_quarter_rate_minus_one_o  output  COUNTER_WIDTH
 preemptive_half_rate_minus_one_o  output  COUNTER_WIDTH
 preemptive_quarter_rate_minus_one_o  output  COUNTER_WIDTH
 state_o  output  2  IDLE=0, PRIME=1, RUN=2, DRAIN=3

Function
REQ-003 Derived values, registered, COUNTER_WIDTH modulo, with H=half period, Q=H>>1, L=lead: exp_half=H-2; exp_quarter=Q-1; pre_half=H-L-1; pre_quarter=Q-L-1.
REQ-004 A config SHALL be valid iff H>=4 and L<Q; invalid config never reaches the outputs and yields resp_error_o=1.
REQ-005 cmd_ready_o SHALL be 1 in IDLE and RUN, 0 in PRIME and DRAIN.
REQ-006 resp_valid_o SHALL pulse exactly one cycle, the clk_en cycle after acceptance; exactly one response per accepted command.
REQ-007 IDLE: START valid -> load outputs, go PRIME; START invalid -> error, stay IDLE; RECONFIG valid -> load outputs, stay IDLE; STOP/NOP -> ok, no change.
REQ-008 PRIME lasts one clk_en cycle: set_polarity_o=1, generation_en_o=0; next state RUN.
REQ-009 RUN: generation_en_o=1; STOP -> DRAIN; START -> error, stay RUN; RECONFIG valid -> latch into pending register, set pending flag, go DRAIN; RECONFIG invalid -> error, stay RUN; NOP -> ok.
REQ-010 DRAIN: generation_en_o=0; stay at least one cycle and until gen_busy_i sampled 0; then PRIME with pending values loaded into outputs and pending flag cleared if pending, else IDLE.
REQ-011 Outputs SHALL change only on IDLE/PRIME transitions, never while generation_en_o=1.
REQ-012 clk_en=0 SHALL hold all state and outputs; set_polarity_o and resp_valid_o pulses are extended by held cycles, not duplicated.
REQ-013 Command accepted the same cycle DRAIN exits is impossible (ready=0); no other simultaneous-event case exists.

Reset
REQ-014 rst=1 SHALL asynchronously force state IDLE, pending flag 0, every output 0 (cmd_ready_o=0 while rst asserted, 1 first cycle after release).
REQ-015 rst mid-operation (any state) SHALL drop generation_en_o immediately and discard pending config and outstanding response.

Configuration
REQ-016 Macro GENERATION_SEQUENCER_ERR_COUNT_EN: when defined, adds output err_count_o (8 bits), incremented on every error response, saturating at 255, cleared by rst; when undefined, port and counter absent, behaviour otherwise identical.

Verification
REQ-017 START H=16 L=3 pol=1 from IDLE -> resp ok; outputs 14,7,12,4; set_polarity_o one cycle; generation_en_o=1 next cycle.
REQ-018 START H=3 L=0 -> resp_error_o=1, state stays IDLE, outputs remain 0; START H=8 L=4 -> error (L>=Q).
REQ-019 RUN, RECONFIG H=20 L=2, gen_busy_i held 1 for 5 cycles -> DRAIN 5+ cycles, outputs unchanged until PRIME, then 18,9,17,7, RUN.
REQ-020 RUN, STOP, gen_busy_i low -> DRAIN one cycle, IDLE; START while RUN -> error, no state change.
REQ-021 rst asserted asynchronously in RUN mid-cycle -> generation_en_o 0 before next edge; after release, state_o=0, cmd_ready_o=1.
REQ-022 With GENERATION_SEQUENCER_ERR_COUNT_EN, 300 invalid STARTs -> err_count_o=255.
